mtimer_unit: RTL and testbench

//  Memory-mapped RISC-V machine timer (mtime/mtimecmp) with prescaler and timer interrupt.

---
 rtl/mtimer_pkg.sv | 19 +
 rtl/mtimer_if.sv | 21 ++
 rtl/mtimer_prescaler.sv | 33 +++
 rtl/mtimer_unit.sv | 135 +++++++++++++
 tb/tb_mtimer_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mtimer_pkg.sv
// Shared definitions for the machine timer: register word offsets,
// CTRL bit positions and the default mtimecmp reset value.
package mtimer_pkg;

  // Word index (bus_addr[4:2]) of each mapped register
  localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
  localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] OFF_CTRL        = 3'd4;

  // CTRL register bit positions
  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_IE = 1;

  // All-ones compare value keeps the interrupt quiet after reset
  localparam logic [63:0] CMP_RESET_DEFAULT = '1;

endpackage

// File: rtl/mtimer_if.sv
// Peripheral bus between the data-bus fabric (master) and the timer (slave).
//   bus_req/bus_we/bus_addr/bus_wdata : request side, held until bus_ack
//   bus_rdata/bus_ack                 : completion side, one-cycle ack pulse
interface mtimer_if;
  logic        bus_req;
  logic        bus_we;
  logic [4:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mtimer_prescaler.sv
// Clock prescaler for mtime.
//   clk, rst : clock, asynchronous active-high reset
//   en       : count enable; 0 freezes the count
//   clr      : synchronous clear to 0 (wins over en)
//   tick     : high on the cycle the count equals PRESCALE-1
// PRESCALE is the number of clk cycles per tick, 1..65535.
module mtimer_prescaler #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] cnt;

  assign tick = en & (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 16'd1;
    end
  end

endmodule

// File: rtl/mtimer_unit.sv
// Memory-mapped RISC-V machine timer (mtime / mtimecmp) with prescaler
// and level timer interrupt.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : slave side of the peripheral bus (mtimer_if)
//   real_mtime : live 64-bit mtime register value
//   timer_irq  : machine timer interrupt, level
// Register map (word offsets): 0x00 MTIME_LO, 0x04 MTIME_HI,
// 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL {IE, EN};
// 0x14..0x1C read 0, ignore writes, still acked.
module mtimer_unit
  import mtimer_pkg::*;
#(
  parameter int unsigned PRESCALE  = 4,
  parameter logic [63:0] CMP_RESET = CMP_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  mtimer_if.slave     bus,
  output logic [63:0] real_mtime,
  output logic        timer_irq
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        ctrl_en;
  logic        ctrl_ie;
  logic        tick;
  logic        accept;
  logic        wr;
  logic [2:0]  idx;
  logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
  logic        presc_clr;
  logic        pend_next;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  // A request is taken only when no ack is outstanding, so a held
  // request completes at most every second cycle.
  assign accept = bus.bus_req & ~bus.bus_ack;
  assign wr     = accept & bus.bus_we;
  assign idx    = bus.bus_addr[4:2];

  assign unused_addr_bits = ^bus.bus_addr[1:0];

  assign wr_mtime_lo = wr & (idx == OFF_MTIME_LO);
  assign wr_mtime_hi = wr & (idx == OFF_MTIME_HI);
  assign wr_cmp_lo   = wr & (idx == OFF_MTIMECMP_LO);
  assign wr_cmp_hi   = wr & (idx == OFF_MTIMECMP_HI);
  assign wr_ctrl     = wr & (idx == OFF_CTRL);

  assign presc_clr = wr_mtime_lo | wr_mtime_hi | wr_cmp_lo | wr_cmp_hi;

  mtimer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (ctrl_en),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_comb begin
    rd_mux = '0;
    case (idx)
      OFF_MTIME_LO:    rd_mux = mtime[31:0];
      OFF_MTIME_HI:    rd_mux = mtime[63:32];
      OFF_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
      OFF_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
      OFF_CTRL:        rd_mux = {30'd0, ctrl_ie, ctrl_en};
      default:         rd_mux = '0;
    endcase
  end

  // A software write to either half drops a coincident tick entirely;
  // the untouched half keeps its old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime <= '0;
    end else if (wr_mtime_lo) begin
      mtime[31:0] <= bus.bus_wdata;
    end else if (wr_mtime_hi) begin
      mtime[63:32] <= bus.bus_wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp <= CMP_RESET;
    end else if (wr_cmp_lo) begin
      mtimecmp[31:0] <= bus.bus_wdata;
    end else if (wr_cmp_hi) begin
      mtimecmp[63:32] <= bus.bus_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en <= 1'b1;
      ctrl_ie <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_en <= bus.bus_wdata[CTRL_EN];
      ctrl_ie <= bus.bus_wdata[CTRL_IE];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bus_ack   <= 1'b0;
      bus.bus_rdata <= '0;
    end else begin
      bus.bus_ack <= accept;
      if (accept) begin
        bus.bus_rdata <= bus.bus_we ? '0 : rd_mux;
      end
    end
  end

  // Compare on the registered values; the irq register adds the single
  // cycle of lag, so no separate pending register is kept.
  assign pend_next = (mtime >= mtimecmp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_irq <= 1'b0;
    end else begin
      timer_irq <= pend_next & ctrl_ie;
    end
  end

  assign real_mtime = mtime;

endmodule

// File: tb/tb_mtimer_unit.sv
module tb_mtimer_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] real_mtime;
  logic        timer_irq;

  int vectors    = 0;
  int miscompares = 0;

  mtimer_if bus ();

  mtimer_unit #(
    .PRESCALE  (4),
    .CMP_RESET (64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .real_mtime (real_mtime),
    .timer_irq  (timer_irq)
  );

  always #5 clk = ~clk;

  // Reset held across two falling edges, released on a falling edge.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Accept on the next rising edge, ends 1ns after the following edge.
  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.bus_req   = 1'b1;
    bus.bus_we    = 1'b1;
    bus.bus_addr  = addr;
    bus.bus_wdata = data;
    @(posedge clk);
    #1;
    bus.bus_req = 1'b0;
    bus.bus_we  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic ack);
    @(negedge clk);
    bus.bus_req  = 1'b1;
    bus.bus_we   = 1'b0;
    bus.bus_addr = addr;
    @(posedge clk);
    #1;
    data = bus.bus_rdata;
    ack  = bus.bus_ack;
    bus.bus_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        a;
    do_reset();
    repeat (10) @(posedge clk);
    #1;
    vectors++;
    if (real_mtime !== 64'd2) begin
      miscompares++;
      $display("FAIL pre_reset_mtime: got %0h expected 2", real_mtime);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (real_mtime !== 64'd0 || timer_irq !== 1'b0 || bus.bus_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: mtime=%0h irq=%b ack=%b expected 0/0/0",
               real_mtime, timer_irq, bus.bus_ack);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_read(5'h10, d, a);
    vectors++;
    if (d !== 32'h1 || a !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %h ack=%b expected 00000001 ack=1", d, a);
    end
    bus_read(5'h0C, d, a);
    vectors++;
    if (d !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL reset_cmp_hi: got %h expected ffffffff", d);
    end
  endtask

  task automatic test_count_enable();
    do_reset();
    repeat (40) @(posedge clk);
    #1;
    vectors++;
    if (real_mtime !== 64'd10) begin
      miscompares++;
      $display("FAIL count_40: got %0d expected 10", real_mtime);
    end
    bus_write(5'h10, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (real_mtime !== 64'd10) begin
      miscompares++;
      $display("FAIL freeze: got %0d expected 10", real_mtime);
    end
    bus_write(5'h10, 32'h1);
    @(posedge clk);
    #1;
    vectors++;
    if (real_mtime !== 64'd10) begin
      miscompares++;
      $display("FAIL resume_early: got %0d expected 10", real_mtime);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (real_mtime !== 64'd11) begin
      miscompares++;
      $display("FAIL resume: got %0d expected 11", real_mtime);
    end
  endtask

  task automatic test_irq();
    int n;
    logic seen_irq;
    do_reset();
    bus_write(5'h10, 32'h3);
    bus_write(5'h0C, 32'h0);
    bus_write(5'h08, 32'h5);
    n = 0;
    while (real_mtime !== 64'd5 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    vectors++;
    if (real_mtime !== 64'd5) begin
      miscompares++;
      $display("FAIL irq_wait_mtime5: got %0d expected 5 (timeout)", real_mtime);
    end
    vectors++;
    if (timer_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_lag: got %b expected 0", timer_irq);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (timer_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL irq_rise: got %b expected 1", timer_irq);
    end
    bus_write(5'h08, 32'd100);
    vectors++;
    if (timer_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_fall: got %b expected 0", timer_irq);
    end
    bus_write(5'h10, 32'h1);
    bus_write(5'h08, 32'h5);
    seen_irq = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (timer_irq !== 1'b0) seen_irq = 1'b1;
    end
    vectors++;
    if (seen_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_ie0: irq seen=%b expected 0", seen_irq);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus_write(5'h00, 32'hFFFF_FFFF);
    bus_write(5'h04, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (real_mtime !== 64'h0000_0000_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL carry_pre: got %h expected 00000000ffffffff", real_mtime);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (real_mtime !== 64'h0000_0001_0000_0000) begin
      miscompares++;
      $display("FAIL carry: got %h expected 0000000100000000", real_mtime);
    end
    bus_write(5'h10, 32'h3);
    bus_write(5'h0C, 32'h0);
    bus_write(5'h08, 32'd10);
    bus_write(5'h00, 32'hFFFF_FFFF);
    bus_write(5'h04, 32'hFFFF_FFFF);
    vectors++;
    if (real_mtime !== 64'hFFFF_FFFF_FFFF_FFFF || timer_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_pre: mtime=%h irq=%b expected ffffffffffffffff/1",
               real_mtime, timer_irq);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (real_mtime !== 64'd0 || timer_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap: mtime=%h irq=%b expected 0/1", real_mtime, timer_irq);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (timer_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_irq_clear: got %b expected 0", timer_irq);
    end
  endtask

  task automatic test_collision();
    do_reset();
    bus_write(5'h04, 32'h0000_ABCD);
    repeat (2) @(posedge clk);
    bus_write(5'h00, 32'h0000_1234);
    vectors++;
    if (real_mtime !== 64'h0000_ABCD_0000_1234) begin
      miscompares++;
      $display("FAIL collide_lo: got %h expected 0000abcd00001234", real_mtime);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (real_mtime !== 64'h0000_ABCD_0000_1234) begin
      miscompares++;
      $display("FAIL collide_hold: got %h expected 0000abcd00001234", real_mtime);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (real_mtime !== 64'h0000_ABCD_0000_1235) begin
      miscompares++;
      $display("FAIL collide_next: got %h expected 0000abcd00001235", real_mtime);
    end
    repeat (3) @(posedge clk);
    bus_write(5'h04, 32'h0000_5555);
    vectors++;
    if (real_mtime !== 64'h0000_5555_0000_1235) begin
      miscompares++;
      $display("FAIL collide_hi: got %h expected 0000555500001235", real_mtime);
    end
  endtask

  task automatic test_back_to_back();
    int acks;
    logic [31:0] d;
    logic        a;
    do_reset();
    acks = 0;
    @(negedge clk);
    bus.bus_req  = 1'b1;
    bus.bus_we   = 1'b0;
    bus.bus_addr = 5'h10;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.bus_ack === 1'b1) acks++;
    end
    bus.bus_req = 1'b0;
    vectors++;
    if (acks !== 3) begin
      miscompares++;
      $display("FAIL held_req_acks: got %0d expected 3", acks);
    end
    bus_read(5'h18, d, a);
    vectors++;
    if (d !== 32'h0 || a !== 1'b1) begin
      miscompares++;
      $display("FAIL unmapped_read: got %h ack=%b expected 00000000 ack=1", d, a);
    end
    bus_write(5'h14, 32'h0);
    bus_read(5'h10, d, a);
    vectors++;
    if (d !== 32'h1) begin
      miscompares++;
      $display("FAIL unmapped_write: ctrl got %h expected 00000001", d);
    end
    @(negedge clk);
    bus.bus_req   = 1'b1;
    bus.bus_we    = 1'b1;
    bus.bus_addr  = 5'h08;
    bus.bus_wdata = 32'h77;
    @(posedge clk);
    #1;
    bus.bus_req = 1'b0;
    bus.bus_we  = 1'b0;
    vectors++;
    if (bus.bus_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL ack_before_rst: got %b expected 1", bus.bus_ack);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.bus_ack !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_abort: got %b expected 0", bus.bus_ack);
    end
    @(negedge clk);
    rst = 1'b0;
    bus_read(5'h08, d, a);
    vectors++;
    if (d !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL no_partial_write: cmp_lo got %h expected ffffffff", d);
    end
  endtask

  initial begin
    bus.bus_req   = 1'b0;
    bus.bus_we    = 1'b0;
    bus.bus_addr  = '0;
    bus.bus_wdata = '0;
    test_reset();
    test_count_enable();
    test_irq();
    test_wrap();
    test_collision();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
